sd_sector_ctrl: RTL
===================

# sd_sector_ctrl

Sector-level sequencer between user read/write ports and the SD SPI command layer. Accepts one 512-byte sector read or write request at a time and arbitrates between concurrent requesters with alternating priority. Issues CMD17/CMD24 through the command layer and drives its block read/write handshakes. After each write, issues CMD13 to confirm the card is no longer busy. Retries failed commands and reports a per-transfer error flag.

## Interface
- RETRY_MAX, 3: total command attempts per command before a transfer fails (1..15).
- SDHC, 1: 1 = the 32-bit address is a block address; 0 = the argument is addr<<9 (byte addressing, truncated to 32 bits).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sd_init_done  in  1  card initialised; no request is accepted while low
- sec_read_req  in  1  level read request, held until sec_read_req_ack
- sec_read_addr  in  32  sector address, sampled at accept
- sec_read_req_ack  out  1  one-cycle completion pulse
- sec_read_data  out  8  read byte
- sec_read_data_valid  out  1  sec_read_data qualifier
- sec_write_req  in  1  level write request, held until sec_write_req_ack
- sec_write_addr  in  32  sector address, sampled at accept
- sec_write_data_rd  out  1  pulse; sec_write_data must be valid on the next cycle
- sec_write_data  in  8  write byte
- sec_write_req_ack  out  1  one-cycle completion pulse
- sec_error  out  1  valid with either ack; held until the next accept
- cmd_req  out  1  command request to the command layer
- cmd_req_ack  in  1  command done pulse
- cmd_req_error  in  1  command failed, valid with cmd_req_ack
- cmd  out  48  {index, argument, 8'hFF}
- cmd_r1  out  8  expected R1, always 8'h00
- cmd_data_len  out  16  trailing bytes to read after R1
- block_read_req  out  1  block read request
- block_read_valid  in  1  block read data valid
- block_read_data  in  8  block read data
- block_read_req_ack  in  1  block read done pulse
- block_write_req  out  1  block write request
- block_write_data  out  8  block write data
- block_write_data_rd  in  1  block write data strobe
- block_write_req_ack  in  1  block write done pulse

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, WR_STAT, DONE.
- IDLE, with sd_init_done=1:
  - Only one request pending: accept it.
  - Both pending: grant the type not served last. last_grant resets to write, so read wins the first tie.
  - On accept: latch the address, clear sec_error and the retry count, then go to RD_CMD or WR_CMD.
- RD_CMD: cmd={8'd17, arg, 8'hFF}, cmd_data_len=0. On a good ack, go to RD_DATA.
- RD_DATA:
  - block_read_req=1.
  - sec_read_data/valid are a combinational pass-through of block_read_data/valid, gated to this state.
  - A 10-bit counter counts valid bytes.
  - On block_read_req_ack, go to DONE. If the count is not 512, set sec_error.
- WR_CMD: cmd={8'd24, arg, 8'hFF}, cmd_data_len=0. On a good ack, go to WR_DATA.
- WR_DATA:
  - block_write_req=1.
  - sec_write_data_rd = block_write_data_rd, gated to this state.
  - block_write_data = sec_write_data.
  - On block_write_req_ack, go to WR_STAT.
- WR_STAT: cmd={8'd13, 32'd0, 8'hFF}, cmd_data_len=1. On a good ack, go to DONE.
- Command errors (cmd_req_error=1 with ack):
  - Increment the retry count and reissue the same command.
  - When the count reaches RETRY_MAX, set sec_error and go to DONE. No data phase runs.
- DONE: pulse the ack of the granted type for exactly one cycle, then IDLE.
- sd_init_done falling mid-transfer has no effect; the transfer completes.

## Timing
- Reset values:
  - All outputs 0, except cmd_r1=8'h00 and cmd=48'h0.
  - State IDLE, last_grant=write.
- Command-layer handshakes:
  - cmd_req, block_read_req and block_write_req are registered.
  - Each is asserted on state entry and held until its ack is seen.
  - Each is deasserted on the clock edge that samples the ack, so it is low in the cycle after the ack.
- cmd is stable from cmd_req rise until ack.
- Accept latency: request high in IDLE → cmd_req high 1 cycle later.
- Requester side:
  - Requesters must drop their req on the edge that samples the ack.
  - IDLE re-evaluates requests the cycle after DONE, so there is no double accept.
- Read data path: 0-cycle latency from the command layer.
- Write data path: 1-cycle strobe-to-data latency, inherited from the command layer.

## Test plan
- Read, addr 0x0000_1234, SDHC=1: cmd[39:8]=0x0000_1234, cmd[47:40]=17; exactly 512 valid bytes; one sec_read_req_ack with sec_error=0.
- Write, addr 5, SDHC=0:
  - cmd[39:8]=0x0000_0A00.
  - 512 sec_write_data_rd pulses; bytes are forwarded unchanged.
  - CMD13 issued with cmd_data_len=1.
  - Ack with sec_error=0.
- Simultaneous read+write from reset: read served first, then write. Next tie: read served first again (last_grant=write).
- cmd_req_error on 2 consecutive CMD17 attempts (RETRY_MAX=3): third attempt issued and succeeds; sec_error=0. With errors on all 3 attempts: no block_read_req, ack with sec_error=1.
- Requests held while sd_init_done=0: no cmd_req. Raise sd_init_done: cmd_req follows 1 cycle later.
- rst asserted mid-RD_DATA: all outputs 0 immediately; a subsequent read completes normally.

Source files
------------

// File: rtl/sd_sector_ctrl_if.sv
// Bundle of the user sector ports and the SD command-layer handshakes.
// slave is the sector sequencer; master is the requester/command-layer side.
interface sd_sector_ctrl_if;
    logic        sd_init_done;
    logic        sec_read_req;
    logic [31:0] sec_read_addr;
    logic        sec_read_req_ack;
    logic [7:0]  sec_read_data;
    logic        sec_read_data_valid;
    logic        sec_write_req;
    logic [31:0] sec_write_addr;
    logic        sec_write_data_rd;
    logic [7:0]  sec_write_data;
    logic        sec_write_req_ack;
    logic        sec_error;
    logic        cmd_req;
    logic        cmd_req_ack;
    logic        cmd_req_error;
    logic [47:0] cmd;
    logic [7:0]  cmd_r1;
    logic [15:0] cmd_data_len;
    logic        block_read_req;
    logic        block_read_valid;
    logic [7:0]  block_read_data;
    logic        block_read_req_ack;
    logic        block_write_req;
    logic [7:0]  block_write_data;
    logic        block_write_data_rd;
    logic        block_write_req_ack;

    modport slave (
        input  sd_init_done, sec_read_req, sec_read_addr, sec_write_req, sec_write_addr,
               sec_write_data, cmd_req_ack, cmd_req_error, block_read_valid,
               block_read_data, block_read_req_ack, block_write_data_rd, block_write_req_ack,
        output sec_read_req_ack, sec_read_data, sec_read_data_valid, sec_write_data_rd,
               sec_write_req_ack, sec_error, cmd_req, cmd, cmd_r1, cmd_data_len,
               block_read_req, block_write_req, block_write_data
    );

    modport master (
        output sd_init_done, sec_read_req, sec_read_addr, sec_write_req, sec_write_addr,
               sec_write_data, cmd_req_ack, cmd_req_error, block_read_valid,
               block_read_data, block_read_req_ack, block_write_data_rd, block_write_req_ack,
        input  sec_read_req_ack, sec_read_data, sec_read_data_valid, sec_write_data_rd,
               sec_write_req_ack, sec_error, cmd_req, cmd, cmd_r1, cmd_data_len,
               block_read_req, block_write_req, block_write_data
    );
endinterface

// File: rtl/sd_sector_ctrl.sv
// Sector read/write sequencer: arbitrates user requests, issues CMD17/CMD24/CMD13
// with retries, and steers the block data handshakes of the SD command layer.
module sd_sector_ctrl #(
    parameter int RETRY_MAX = 3,
    parameter bit SDHC      = 1'b1
) (
    input  logic            sys_clk,
    input  logic            rst,
    sd_sector_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_CMD  = 3'd3,
        WR_DATA = 3'd4,
        WR_STAT = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [3:0]  RETRY_LIMIT  = 4'(RETRY_MAX);
    localparam logic [7:0]  CMD_READ     = 8'd17;
    localparam logic [7:0]  CMD_WRITE    = 8'd24;
    localparam logic [7:0]  CMD_STATUS   = 8'd13;
    localparam logic [9:0]  SECTOR_BYTES = 10'd512;

    state_t      state_r, state_s;
    logic        last_write_r, last_write_s;
    logic        xfer_write_r, xfer_write_s;
    logic [31:0] addr_r, addr_s;
    logic [3:0]  retry_r, retry_s;
    logic [9:0]  byte_cnt_r, byte_cnt_s;
    logic        sec_error_r, sec_error_s;
    logic        cmd_req_r, cmd_req_s;
    logic [47:0] cmd_r, cmd_s;
    logic [15:0] cmd_data_len_r, cmd_data_len_s;
    logic        block_read_req_r, block_read_req_s;
    logic        block_write_req_r, block_write_req_s;
    logic        read_ack_r, read_ack_s;
    logic        write_ack_r, write_ack_s;

    logic        cmd_ack_s, cmd_good_s, cmd_bad_s;
    logic        accept_s, accept_write_s, cmd_state_s;
    logic [3:0]  retry_inc_s;
    logic [9:0]  cnt_inc_s;

    // Byte addressing shifts the sector number into a 512-byte offset.
    function automatic logic [31:0] sector_arg(input logic [31:0] addr);
        return SDHC ? addr : {addr[22:0], 9'd0};
    endfunction

    // Acks only count while the matching request is actually outstanding.
    assign cmd_ack_s      = cmd_req_r & bus.cmd_req_ack;
    assign cmd_good_s     = cmd_ack_s & ~bus.cmd_req_error;
    assign cmd_bad_s      = cmd_ack_s & bus.cmd_req_error;
    assign retry_inc_s    = retry_r + 4'd1;
    assign cnt_inc_s      = byte_cnt_r + {9'd0, bus.block_read_valid};
    assign accept_s       = bus.sd_init_done & (bus.sec_read_req | bus.sec_write_req);
    assign accept_write_s = bus.sec_write_req & (~bus.sec_read_req | ~last_write_r);

    // Next-state and transfer bookkeeping.
    always_comb begin
        state_s      = state_r;
        last_write_s = last_write_r;
        xfer_write_s = xfer_write_r;
        addr_s       = addr_r;
        retry_s      = retry_r;
        byte_cnt_s   = byte_cnt_r;
        sec_error_s  = sec_error_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    xfer_write_s = accept_write_s;
                    last_write_s = accept_write_s;
                    addr_s       = accept_write_s ? bus.sec_write_addr : bus.sec_read_addr;
                    retry_s      = 4'd0;
                    byte_cnt_s   = 10'd0;
                    sec_error_s  = 1'b0;
                    state_s      = accept_write_s ? WR_CMD : RD_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_CMD, WR_CMD, WR_STAT: begin
                if (cmd_good_s) begin
                    retry_s = 4'd0;
                    case (state_r)
                        RD_CMD:  state_s = RD_DATA;
                        WR_CMD:  state_s = WR_DATA;
                        default: state_s = DONE;
                    endcase
                end else if (cmd_bad_s) begin
                    retry_s = retry_inc_s;
                    if (retry_inc_s >= RETRY_LIMIT) begin
                        sec_error_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RD_DATA: begin
                byte_cnt_s = cnt_inc_s;
                if (block_read_req_r & bus.block_read_req_ack) begin
                    sec_error_s = (cnt_inc_s != SECTOR_BYTES);
                    state_s     = DONE;
                end else begin
                    state_s = RD_DATA;
                end
            end
            WR_DATA: begin
                if (block_write_req_r & bus.block_write_req_ack) begin
                    state_s = WR_STAT;
                end else begin
                    state_s = WR_DATA;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered handshake and command outputs.
    always_comb begin
        cmd_s             = cmd_r;
        cmd_data_len_s    = cmd_data_len_r;
        cmd_state_s       = (state_s == RD_CMD) || (state_s == WR_CMD) || (state_s == WR_STAT);
        cmd_req_s         = cmd_state_s & ~cmd_ack_s;
        block_read_req_s  = (state_s == RD_DATA);
        block_write_req_s = (state_s == WR_DATA);
        read_ack_s        = (state_s == DONE) & ~xfer_write_s;
        write_ack_s       = (state_s == DONE) & xfer_write_s;
        case (state_s)
            RD_CMD: begin
                cmd_s          = {CMD_READ, sector_arg(addr_s), 8'hFF};
                cmd_data_len_s = 16'd0;
            end
            WR_CMD: begin
                cmd_s          = {CMD_WRITE, sector_arg(addr_s), 8'hFF};
                cmd_data_len_s = 16'd0;
            end
            WR_STAT: begin
                cmd_s          = {CMD_STATUS, 32'd0, 8'hFF};
                cmd_data_len_s = 16'd1;
            end
            default: begin
                cmd_s          = cmd_r;
                cmd_data_len_s = cmd_data_len_r;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r           <= IDLE;
            last_write_r      <= 1'b1;
            xfer_write_r      <= 1'b0;
            addr_r            <= 32'd0;
            retry_r           <= 4'd0;
            byte_cnt_r        <= 10'd0;
            sec_error_r       <= 1'b0;
            cmd_req_r         <= 1'b0;
            cmd_r             <= 48'h0;
            cmd_data_len_r    <= 16'd0;
            block_read_req_r  <= 1'b0;
            block_write_req_r <= 1'b0;
            read_ack_r        <= 1'b0;
            write_ack_r       <= 1'b0;
        end else begin
            state_r           <= state_s;
            last_write_r      <= last_write_s;
            xfer_write_r      <= xfer_write_s;
            addr_r            <= addr_s;
            retry_r           <= retry_s;
            byte_cnt_r        <= byte_cnt_s;
            sec_error_r       <= sec_error_s;
            cmd_req_r         <= cmd_req_s;
            cmd_r             <= cmd_s;
            cmd_data_len_r    <= cmd_data_len_s;
            block_read_req_r  <= block_read_req_s;
            block_write_req_r <= block_write_req_s;
            read_ack_r        <= read_ack_s;
            write_ack_r       <= write_ack_s;
        end
    end

    // Data paths are straight pass-throughs, gated to their data states.
    assign bus.sec_read_data_valid = (state_r == RD_DATA) & bus.block_read_valid;
    assign bus.sec_read_data       = (state_r == RD_DATA) ? bus.block_read_data : 8'h00;
    assign bus.sec_write_data_rd   = (state_r == WR_DATA) & bus.block_write_data_rd;
    assign bus.block_write_data    = (state_r == WR_DATA) ? bus.sec_write_data : 8'h00;

    assign bus.sec_read_req_ack  = read_ack_r;
    assign bus.sec_write_req_ack = write_ack_r;
    assign bus.sec_error         = sec_error_r;
    assign bus.cmd_req           = cmd_req_r;
    assign bus.cmd               = cmd_r;
    assign bus.cmd_r1            = 8'h00;
    assign bus.cmd_data_len      = cmd_data_len_r;
    assign bus.block_read_req    = block_read_req_r;
    assign bus.block_write_req   = block_write_req_r;

endmodule
